e_mdu: RTL and testbench
========================

# e_mdu

Parametrised multi-cycle multiply/divide unit for the E stage, beside the ALU; owns the HI/LO register pair. A start strobe latches operands and operation. The unit stays busy for a fixed operation-dependent latency, then commits the result to HI/LO. The pipeline controller uses `start | busy` to stall any following HI/LO-touching instruction in D.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult-class ops (≥1)
- DIV_CYCLES, 10, busy cycles for div-class ops (≥1)

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  issue strobe for md_op this cycle
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11–15 none
- kill  input  1  exception/flush in E; cancels an issue in the same cycle
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- busy  output  1  operation in flight
- hi  output  WIDTH  current HI register
- lo  output  WIDTH  current LO register

Clock and reset are single-clock, synchronous, active-high (`clk`, `reset`), as fixed above.

## Operation
- Reset values: busy=0, hi=0, lo=0, state IDLE, counter 0.
- States:
  - IDLE: no operation in flight.
  - RUN: an operation is counting down.
- Issue: an issue is accepted only when start=1, kill=0, state=IDLE, and md_op is valid.
  - If start=1 while busy, the request is ignored; the controller must already be stalling.
- mthi/mtlo: HI or LO takes A at the next edge. No busy cycle. State stays IDLE.
- mult/div class: operands and op are latched. The result is precomputed or iterated internally. State goes to RUN with counter = N−1, where N = MULT_CYCLES or DIV_CYCLES.
- In RUN, the counter decrements each cycle. When counter = 0, HI/LO are written at that edge and the state returns to IDLE.
- Arithmetic:
  - mult: {hi,lo} = signed A × signed B, full 2·WIDTH product.
  - multu: same as mult, unsigned.
  - madd/maddu: {hi,lo} += product.
  - msub/msubu: {hi,lo} −= product.
  - Accumulate uses the HI/LO value at commit, modulo 2^(2·WIDTH).
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed −2^(WIDTH−1) / −1: lo = −2^(WIDTH−1), hi = 0.
  - Divide by zero: full DIV_CYCLES latency, but HI/LO are left unchanged.
- kill has no effect on an operation already in RUN; it still completes.
- reset mid-operation aborts the operation: state returns to IDLE and HI/LO are cleared.

## Timing
- Issue in cycle t gives busy=1 in cycles t+1 … t+N.
- The new hi/lo are visible and busy=0 in cycle t+N+1.
- A new issue is accepted no earlier than cycle t+N+1.
- mthi/mtlo issued in cycle t are visible in cycle t+1; busy stays 0.
- hi/lo are direct register outputs, so they are stable throughout RUN (the old value is held).
- Same-cycle start and kill: nothing is latched and busy stays 0.

## Configuration
- MDU_MADD_EN defined: madd, maddu, msub and msubu are supported as above, with MULT_CYCLES latency.
- MDU_MADD_EN undefined: md_op 7–10 decode as none. There is no busy cycle, no HI/LO write, and no accumulate adder is built.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3. Expect busy in cycles 1–5, then hi=0xFFFFFFFF and lo=0xFFFFFFFA; multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div with A=−7, B=2. Expect lo=0xFFFFFFFD and hi=0xFFFFFFFF after 10 busy cycles. Follow with divu by B=0: hi/lo stay unchanged and busy still lasts 10 cycles.
- mthi A=0x12345678 with busy=0: hi updates the next cycle. Then start=1 with div while a mult is in flight: the second request is ignored and only the mult result commits.
- start=1 with kill=1 for mult: busy stays 0 and hi/lo stay unchanged. Reset asserted at busy cycle 3 of a div: the next cycle shows busy=0, hi=lo=0.
- With MDU_MADD_EN defined, hi=0, lo=0xFFFFFFFF, then maddu with A=1, B=1: expect hi=1, lo=0. Without MDU_MADD_EN the same stimulus leaves hi/lo unchanged and busy stays 0.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Ports: clk/reset (sync, active-high); start+md_op issue an op unless kill;
//   A/B operands; busy high while an op counts down; hi/lo are the registers.
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu (md_op 7-10).
// The result is computed at issue and held; HI/LO change only at commit.
module e_mdu #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic             kill,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [1:0] M_SET = 2'd0, M_NONE = 2'd3;
`ifdef MDU_MADD_EN
  localparam logic [1:0] M_ADD = 2'd1, M_SUB = 2'd2;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] res, prod, ax, bx;
  logic [1:0] mode, mode_n;
  logic is_mul, is_div, is_acc, sgn, issue, neg_a, neg_b;
  logic [WIDTH-1:0] ua, ub, uq, ur, quot, rem;
  assign is_mul = md_op == 4'd1 || md_op == 4'd2;
  assign is_div = md_op == 4'd3 || md_op == 4'd4;
`ifdef MDU_MADD_EN
  assign is_acc = md_op >= 4'd7 && md_op <= 4'd10;
  assign mode_n = (md_op == 4'd9 || md_op == 4'd10) ? M_SUB :
                  (md_op == 4'd7 || md_op == 4'd8) ? M_ADD :
                  (is_div && B == '0) ? M_NONE : M_SET;
`else
  assign is_acc = 1'b0;
  assign mode_n = (is_div && B == '0) ? M_NONE : M_SET;
`endif
  assign sgn = md_op == 4'd1 || md_op == 4'd3 || md_op == 4'd7 || md_op == 4'd9;
  assign issue = start && !kill && state == IDLE;
  // Sign-extending to 2*WIDTH lets one truncated multiply serve both signednesses.
  assign ax = {{WIDTH{sgn & A[WIDTH-1]}}, A};
  assign bx = {{WIDTH{sgn & B[WIDTH-1]}}, B};
  assign prod = ax * bx;
  // Divide on magnitudes, then restore signs; a zero divisor is replaced by 1
  // only to keep the divider defined, its result is discarded.
  assign neg_a = sgn & A[WIDTH-1];
  assign neg_b = sgn & B[WIDTH-1];
  assign ua = neg_a ? -A : A;
  assign ub = (B == '0) ? WIDTH'(1) : neg_b ? -B : B;
  assign uq = ua / ub;
  assign ur = ua % ub;
  assign quot = (neg_a ^ neg_b) ? -uq : uq;
  assign rem = neg_a ? -ur : ur;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      hi <= '0;
      lo <= '0;
      res <= '0;
      mode <= M_NONE;
    end else if (state == IDLE) begin
      if (issue && md_op == 4'd5) hi <= A;
      if (issue && md_op == 4'd6) lo <= A;
      if (issue && (is_mul || is_div || is_acc)) begin
        state <= RUN;
        busy <= 1'b1;
        cnt <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        res <= is_div ? {rem, quot} : prod;
        mode <= mode_n;
      end
    end else if (cnt == '0) begin
      state <= IDLE;
      busy <= 1'b0;
`ifdef MDU_MADD_EN
      if (mode != M_NONE) {hi, lo} <= mode == M_ADD ? {hi, lo} + res :
                                      mode == M_SUB ? {hi, lo} - res : res;
`else
      if (mode != M_NONE) {hi, lo} <= res;
`endif
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized self-checking bench for e_mdu against a HI/LO arithmetic model.
module tb_e_mdu;
  localparam int W = 32, MC = 5, DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0, busy;
  logic [3:0] md_op = 4'd0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int passed = 0, total = 0;
  e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .kill(kill),
    .A(a), .B(b), .busy(busy), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  function automatic int lat(input logic [3:0] op);
    if (op == 1 || op == 2) return MC;
    if (op == 3 || op == 4) return DC;
    if (op >= 7 && op <= 10) return MADD ? MC : 0;
    return 0;
  endfunction
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, y);
    longint sp;
    logic [63:0] up, acc;
    int qx, qy;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'd0, x} * {32'd0, y};
    acc = {m_hi, m_lo};
    case (op)
      1: acc = sp;
      2: acc = up;
      3: if (y != 0) begin
           if (x == 32'h80000000 && y == 32'hFFFFFFFF) acc = {32'd0, x};
           else begin
             qx = x;
             qy = y;
             acc = {32'(qx % qy), 32'(qx / qy)};
           end
         end
      4: if (y != 0) acc = {x % y, x / y};
      5: acc[63:32] = x;
      6: acc[31:0] = x;
      7: if (MADD) acc = acc + sp;
      8: if (MADD) acc = acc + up;
      9: if (MADD) acc = acc - sp;
      10: if (MADD) acc = acc - up;
      default: ;
    endcase
    {m_hi, m_lo} = acc;
  endfunction
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, y, input string name);
    int n, bad_i;
    logic [W-1:0] oh, ol;
    logic bb;
    n = lat(op);
    oh = m_hi;
    ol = m_lo;
    bad_i = -1;
    bb = 1'b0;
    model(op, x, y);
    md_op = op; a = x; b = y; start = 1'b1; kill = 1'b0;
    @(posedge clk);
    #1 start = 1'b0; md_op = 4'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bad_i < 0 && (busy !== 1'b1 || hi !== oh || lo !== ol)) begin
        bad_i = i;
        bb = busy;
      end
    end
    if (n > 0) begin
      total++;
      if (bad_i >= 0) $display("FAIL %s busy window: cycle %0d busy=%b (hi/lo must hold %h/%h), required busy=1", name, bad_i + 1, bb, oh, ol);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL %s result: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h", name, busy, hi, lo, m_hi, m_lo);
    else passed++;
  endtask
  task automatic chk_hl(input string name, input logic [W-1:0] eh, el);
    total++;
    if (hi !== eh || lo !== el) $display("FAIL %s: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, eh, el);
    else passed++;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL reset: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    else passed++;
  endtask
  task automatic test_mult;
    do_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult");
    chk_hl("mult const", 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op(4'd2, 32'hFFFFFFFE, 32'd3, "multu");
    chk_hl("multu const", 32'h00000002, 32'hFFFFFFFA);
  endtask
  task automatic test_div;
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, "div");
    chk_hl("div const", 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(4'd4, 32'd1234, 32'd0, "divu by zero");
    chk_hl("divu zero const", 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div overflow");
    chk_hl("div overflow const", 32'h00000000, 32'h80000000);
  endtask
  task automatic test_mthi_mtlo;
    do_op(4'd5, 32'h12345678, 32'd0, "mthi");
    chk_hl("mthi const", 32'h12345678, 32'h80000000);
    do_op(4'd6, 32'hCAFEF00D, 32'd0, "mtlo");
    chk_hl("mtlo const", 32'h12345678, 32'hCAFEF00D);
  endtask
  task automatic test_ignore;
    logic bad;
    bad = 1'b0;
    model(4'd1, 32'd7, 32'd9);
    md_op = 4'd1; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (busy !== 1'b1) bad = 1'b1;
    md_op = 4'd3; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; md_op = 4'd0;
    for (int i = 0; i < MC - 1; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL ignore busy window: busy dropped early, required %0d busy cycles", MC);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo)
      $display("FAIL ignore commit: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL ignore late: busy=%b, required 0", busy);
    else passed++;
  endtask
  task automatic test_kill;
    logic bad;
    bad = 1'b0;
    md_op = 4'd1; a = 32'd5; b = 32'd6; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0; md_op = 4'd0;
    repeat (MC + 1) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL kill: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    else passed++;
  endtask
  task automatic test_reset_mid;
    md_op = 4'd3; a = 32'd99; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; md_op = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL reset mid-op: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    else passed++;
    repeat (DC) @(negedge clk);
    chk_hl("reset mid-op stays clear", 32'd0, 32'd0);
  endtask
  task automatic test_madd;
    do_op(4'd5, 32'd0, 32'd0, "madd prep mthi");
    do_op(4'd6, 32'hFFFFFFFF, 32'd0, "madd prep mtlo");
    do_op(4'd8, 32'd1, 32'd1, "maddu");
    if (MADD) chk_hl("maddu const", 32'd1, 32'd0);
    else chk_hl("maddu disabled const", 32'd0, 32'hFFFFFFFF);
    do_op(4'd9, 32'hFFFFFFFF, 32'd3, "msub");
    do_op(4'd7, 32'h80000000, 32'h7FFFFFFF, "madd");
    do_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, "msubu");
  endtask
  task automatic test_random;
    logic [3:0] op;
    logic [W-1:0] x, y;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      do_op(op, x, y, $sformatf("random[%0d] op%0d", i, op));
    end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_ignore;
    test_kill;
    test_reset_mid;
    test_madd;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
